// File: rtl/unified_mem_arb_pkg.sv
// Shared types and default widths for the unified memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;
  typedef enum logic {GNT_I, GNT_D} grant_e;
endpackage

// File: rtl/unified_mem_arb_if.sv
// Core-side fetch/data ports plus memory-side bus of the unified memory arbiter.
interface unified_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              err;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  // environment side: core and memory
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/unified_mem_arb_wdog.sv
// Memory-ack watchdog: fires a one-cycle expired pulse after TIMEOUT waiting cycles.
module arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // the cycle that would bring the count to TIMEOUT is the expiry cycle
  assign expired = en && (cnt_reg == LAST);
endmodule

// File: rtl/unified_mem_arb.sv
// Shares one single-port variable-latency memory between fetch and data ports.
// Optional ARB_RR_EN macro switches fixed data priority to round-robin arbitration.
module unified_mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic reset,
  unified_mem_arb_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_BUSY_I = BUSY_I;
  localparam logic [1:0] ST_BUSY_D = BUSY_D;
  localparam logic [1:0] ST_RESP   = RESP;

  logic [1:0]        state_reg;
  grant_e            grant_reg;
  logic              mem_req_reg, mem_we_reg, if_ready_reg, d_ready_reg, err_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg, if_rdata_reg, d_rdata_reg;
  logic              busy, any_req, pick_d, expired, finish;
  logic [DATA_W-1:0] rsp_next;

  assign busy    = (state_reg == ST_BUSY_I) || (state_reg == ST_BUSY_D);
  assign any_req = bus.if_req || bus.d_req;

`ifdef ARB_RR_EN
  grant_e last_grant_reg;
  // on a tie the port not granted last wins
  assign pick_d = bus.d_req && (!bus.if_req || (last_grant_reg == GNT_I));
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= GNT_I;
    end else if ((state_reg == ST_IDLE) && any_req) begin
      last_grant_reg <= pick_d ? GNT_D : GNT_I;
    end
  end
`else
  assign pick_d = bus.d_req;
`endif

  arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state_reg == ST_IDLE) && any_req),
    .en      (busy && !bus.mem_ack),
    .expired (expired)
  );

  // an ack in the expiry cycle wins; a timeout returns zero data
  assign finish   = busy && (bus.mem_ack || expired);
  assign rsp_next = bus.mem_ack ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= GNT_I;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_ready_reg  <= 1'b0;
      d_ready_reg   <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      if_ready_reg <= 1'b0;
      d_ready_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            grant_reg    <= pick_d ? GNT_D : GNT_I;
            state_reg    <= pick_d ? ST_BUSY_D : ST_BUSY_I;
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= pick_d && bus.d_we;
            mem_addr_reg <= pick_d ? bus.d_addr : bus.if_addr;
            if (pick_d) begin
              mem_wdata_reg <= bus.d_wdata;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (finish) begin
            state_reg   <= ST_RESP;
            mem_req_reg <= 1'b0;
            if (!bus.mem_ack) begin
              err_reg <= 1'b1;
            end
            if (grant_reg == GNT_D) begin
              d_ready_reg <= 1'b1;
              d_rdata_reg <= rsp_next;
            end else begin
              if_ready_reg <= 1'b1;
              if_rdata_reg <= rsp_next;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.if_ready  = if_ready_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_ready   = d_ready_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_unified_mem_arb.sv
// Directed bench for unified_mem_arb (TIMEOUT=4) with hand-computed expectations.
module tb_unified_mem_arb;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  unified_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // advance one cycle; inputs and samples sit 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".mem_req"},   32'(bus.mem_req),  32'd0);
    chk({tag, ".mem_we"},    32'(bus.mem_we),   32'd0);
    chk({tag, ".mem_addr"},  bus.mem_addr,      32'd0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata,     32'd0);
    chk({tag, ".if_ready"},  32'(bus.if_ready), 32'd0);
    chk({tag, ".d_ready"},   32'(bus.d_ready),  32'd0);
    chk({tag, ".if_rdata"},  bus.if_rdata,      32'd0);
    chk({tag, ".d_rdata"},   bus.d_rdata,       32'd0);
    chk({tag, ".err"},       32'(bus.err),      32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 0;
    tick(); tick();
    chk_idle_outputs("reset");
    reset = 1'b0;
    $display("txn reset: outputs checked");

    // single load, ack in cycle 3
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h60;      // cycle 0
    tick();                                                // cycle 1
    chk("load.c1.mem_req", 32'(bus.mem_req), 32'd1);
    chk("load.c1.mem_addr", bus.mem_addr, 32'h60);
    chk("load.c1.mem_we", 32'(bus.mem_we), 32'd0);
    tick();                                                // cycle 2
    chk("load.c2.mem_req", 32'(bus.mem_req), 32'd1);
    tick();                                                // cycle 3
    chk("load.c3.mem_req", 32'(bus.mem_req), 32'd1);
    chk("load.c3.d_ready", 32'(bus.d_ready), 32'd0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h19;
    tick();                                                // cycle 4
    bus.mem_ack = 0; bus.mem_rdata = '0;
    chk("load.c4.d_ready", 32'(bus.d_ready), 32'd1);
    chk("load.c4.d_rdata", bus.d_rdata, 32'h19);
    chk("load.c4.mem_req", 32'(bus.mem_req), 32'd0);
    bus.d_req = 0;
    tick();                                                // cycle 5
    chk("load.c5.d_ready", 32'(bus.d_ready), 32'd0);
    chk("load.c5.mem_req", 32'(bus.mem_req), 32'd0);
    $display("txn load addr=0x60 rdata=0x%08h", bus.d_rdata);

    // simultaneous fetch and load, 1-cycle ack: data first
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;     // cycle 0
    tick();                                                // cycle 1
    chk("tie.c1.mem_addr", bus.mem_addr, 32'h200);
    bus.mem_ack = 1; bus.mem_rdata = 32'hAA;
    tick();                                                // cycle 2
    bus.mem_ack = 0;
    chk("tie.c2.d_ready", 32'(bus.d_ready), 32'd1);
    chk("tie.c2.d_rdata", bus.d_rdata, 32'hAA);
    chk("tie.c2.if_ready", 32'(bus.if_ready), 32'd0);
    bus.d_req = 0;
    tick();                                                // cycle 3: IDLE samples fetch
    chk("tie.c3.mem_req", 32'(bus.mem_req), 32'd0);
    tick();                                                // cycle 4
    chk("tie.c4.mem_req", 32'(bus.mem_req), 32'd1);
    chk("tie.c4.mem_addr", bus.mem_addr, 32'h100);
    chk("tie.c4.mem_we", 32'(bus.mem_we), 32'd0);
    bus.mem_ack = 1; bus.mem_rdata = 32'hBB;
    tick();                                                // cycle 5
    bus.mem_ack = 0;
    chk("tie.c5.if_ready", 32'(bus.if_ready), 32'd1);
    chk("tie.c5.if_rdata", bus.if_rdata, 32'hBB);
    chk("tie.c5.d_ready", 32'(bus.d_ready), 32'd0);
    bus.if_req = 0;
    tick();
    $display("txn tie: data then fetch");

    // store, ack in cycle 2
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h64; bus.d_wdata = 32'd25;
    tick();                                                // cycle 1
    chk("st.c1.mem_we", 32'(bus.mem_we), 32'd1);
    chk("st.c1.mem_addr", bus.mem_addr, 32'h64);
    chk("st.c1.mem_wdata", bus.mem_wdata, 32'd25);
    bus.d_wdata = 32'd99;                                  // ignored while busy
    tick();                                                // cycle 2
    chk("st.c2.mem_we", 32'(bus.mem_we), 32'd1);
    chk("st.c2.mem_wdata", bus.mem_wdata, 32'd25);
    bus.mem_ack = 1; bus.mem_rdata = 32'h5;
    tick();                                                // cycle 3
    bus.mem_ack = 0;
    chk("st.c3.d_ready", 32'(bus.d_ready), 32'd1);
    chk("st.c3.d_rdata", bus.d_rdata, 32'h5);
    chk("st.c3.if_ready", 32'(bus.if_ready), 32'd0);
    bus.d_req = 0; bus.d_we = 0;
    tick();
    $display("txn store addr=0x64 wdata=25");

    // timeout: no ack, mem_req high exactly 4 cycles
    bus.if_req = 1; bus.if_addr = 32'h300;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("to.c%0d.mem_req", c), 32'(bus.mem_req), 32'd1);
    end
    chk("to.c4.err", 32'(bus.err), 32'd0);
    tick();                                                // cycle 5
    chk("to.c5.mem_req", 32'(bus.mem_req), 32'd0);
    chk("to.c5.err", 32'(bus.err), 32'd1);
    chk("to.c5.if_ready", 32'(bus.if_ready), 32'd1);
    chk("to.c5.if_rdata", bus.if_rdata, 32'd0);
    bus.if_req = 0;
    tick();
    bus.if_req = 1; bus.if_addr = 32'h304;
    tick();
    chk("to2.c1.mem_addr", bus.mem_addr, 32'h304);
    bus.mem_ack = 1; bus.mem_rdata = 32'h55;
    tick();
    bus.mem_ack = 0;
    chk("to2.c2.if_ready", 32'(bus.if_ready), 32'd1);
    chk("to2.c2.if_rdata", bus.if_rdata, 32'h55);
    chk("to2.c2.err", 32'(bus.err), 32'd1);
    bus.if_req = 0;
    tick();
    $display("txn timeout: err=%0d", bus.err);

    // reset while a load is in flight
    bus.d_req = 1; bus.d_addr = 32'h80;
    tick();                                                // cycle 1, BUSY_D
    chk("rst.c1.mem_req", 32'(bus.mem_req), 32'd1);
    reset = 1; bus.d_req = 0;
    tick();
    reset = 0;
    chk_idle_outputs("rst.c2");
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD;             // late ack
    tick();
    bus.mem_ack = 0;
    chk("rst.c3.d_ready", 32'(bus.d_ready), 32'd0);
    chk("rst.c3.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst.c3.d_rdata", bus.d_rdata, 32'd0);
    tick();
    chk("rst.c4.d_ready", 32'(bus.d_ready), 32'd0);
    $display("txn reset mid-access");

    // ack in the expiry cycle wins
    bus.if_req = 1; bus.if_addr = 32'h400;
    tick(); tick(); tick(); tick();                        // cycle 4
    chk("ax.c4.mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h77;
    tick();                                                // cycle 5
    bus.mem_ack = 0;
    chk("ax.c5.if_ready", 32'(bus.if_ready), 32'd1);
    chk("ax.c5.if_rdata", bus.if_rdata, 32'h77);
    chk("ax.c5.err", 32'(bus.err), 32'd0);
    bus.if_req = 0;
    tick();
    chk("ax.c6.if_ready", 32'(bus.if_ready), 32'd0);
    $display("txn ack at expiry rdata=0x%08h", bus.if_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
